dmem_lsu: RTL and testbench



---
 rtl/dmem_lsu_pkg.sv | 60 ++++++
 rtl/dmem_bram.sv | 29 ++
 rtl/dmem_lsu.sv | 139 +++++++++++++
 tb/tb_dmem_lsu.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_lsu_pkg.sv
// Shared types and helpers for the dmem_lsu load/store unit.
// DMEM_LSU_MISALIGN_CHECK_EN (optional) enables the misalignment check.
package dmem_lsu_pkg;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Stores only exist as B/H/W; BU/HU are load-only encodings.
  function automatic logic f3_legal(input logic [2:0] f3, input logic we);
    case (f3)
      F3_B, F3_H, F3_W: f3_legal = 1'b1;
      F3_BU, F3_HU:     f3_legal = !we;
      default:          f3_legal = 1'b0;
    endcase
  endfunction

  function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_H, F3_HU: misaligned = off[0];
      F3_W:        misaligned = (off != 2'b00);
      default:     misaligned = 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] be_from(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_B, F3_BU: be_from = 4'b0001 << off;
      F3_H, F3_HU: be_from = off[1] ? 4'b1100 : 4'b0011;
      F3_W:        be_from = 4'b1111;
      default:     be_from = 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off,
                                              input logic [31:0] word);
    logic [31:0] b_sh;
    logic [31:0] h_sh;
    b_sh = word >> {off, 3'b000};
    h_sh = word >> {off[1], 4'b0000};
    case (f3)
      F3_B:    load_extend = {{24{b_sh[7]}}, b_sh[7:0]};
      F3_BU:   load_extend = {24'h0, b_sh[7:0]};
      F3_H:    load_extend = {{16{h_sh[15]}}, h_sh[15:0]};
      F3_HU:   load_extend = {16'h0, h_sh[15:0]};
      F3_W:    load_extend = word;
      default: load_extend = 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_bram.sv
// Word-wide RAM with per-byte write enables and a registered (read-first) output.
// No reset: contents and read register power up undefined.
module dmem_bram #(
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [3:0]        be_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       wdata_i,
  output logic [31:0]       rdata_o
);

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < 4; b++) begin
      if (we_i && be_i[b]) begin
        mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
      end
    end
    rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_lsu.sv
// RV32I data memory + load/store unit with valid/ready request and one-cycle response pulse.
// Optional macro DMEM_LSU_MISALIGN_CHECK_EN rejects misaligned H/W accesses with rsp_err.
module dmem_lsu
  import dmem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [2:0] LOAD_CNT = 3'(READ_LAT);

  // Handshake: a request transfers on a rising edge with req_valid && req_ready;
  // req_ready is high only in IDLE outside reset; rsp_valid is a one-cycle pulse.
  logic        accept;
  logic        is_mis;
  logic        req_err;
  logic        wr_en;
  logic [3:0]  wr_be;
  logic [31:0] wr_data;
  logic [31:0] ram_rdata;
  logic [31:0] load_word;
  logic        unused_addr_bits;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  f3_q;
  logic [1:0]  off_q;
  logic        we_q;
  logic        err_q;

  assign req_ready = (state_q == ST_IDLE) && !rst;
  assign accept    = req_valid && req_ready;

`ifdef DMEM_LSU_MISALIGN_CHECK_EN
  assign is_mis = misaligned(req_funct3, req_addr[1:0]);
`else
  assign is_mis = 1'b0;
`endif

  assign req_err = !f3_legal(req_funct3, req_we) || is_mis;
  assign wr_en   = accept && req_we && !req_err;
  assign wr_be   = be_from(req_funct3, req_addr[1:0]);

  always_comb begin
    wr_data = req_wdata;
    case (req_funct3)
      F3_B:    wr_data = {4{req_wdata[7:0]}};
      F3_H:    wr_data = {2{req_wdata[15:0]}};
      default: wr_data = req_wdata;
    endcase
  end

  // Upper address bits are intentionally ignored so accesses wrap.
  assign unused_addr_bits = ^req_addr[31:AW+2];

  dmem_bram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .ADDR_W     (AW)
  ) u_bram (
    .clk_i  (clk),
    .we_i   (wr_en),
    .be_i   (wr_be),
    .addr_i (req_addr[AW+1:2]),
    .wdata_i(wr_data),
    .rdata_o(ram_rdata)
  );

  if (READ_LAT > 1) begin : g_pipe
    logic [31:0] pipe_q [READ_LAT-1];
    always_ff @(posedge clk) begin
      pipe_q[0] <= ram_rdata;
      for (int i = 1; i < READ_LAT - 1; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
    assign load_word = pipe_q[READ_LAT-2];
  end else begin : g_nopipe
    assign load_word = ram_rdata;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_BUSY;
          cnt_d   = req_we ? 3'd1 : LOAD_CNT;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd1) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= 3'd0;
      f3_q    <= 3'd0;
      off_q   <= 2'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        f3_q  <= req_funct3;
        off_q <= req_addr[1:0];
        we_q  <= req_we;
        err_q <= req_err;
      end
    end
  end

  assign rsp_valid = !rst && (state_q == ST_BUSY) && (cnt_q == 3'd1);
  assign rsp_err   = rsp_valid && err_q;
  assign rsp_rdata = (rsp_valid && !err_q && !we_q) ? load_extend(f3_q, off_q, load_word)
                                                    : 32'h0;

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed, table-driven bench for dmem_lsu (DEPTH_WORDS=64, READ_LAT=3).
module tb_dmem_lsu;

  localparam int DW  = 64;
  localparam int LAT = 3;
`ifdef DMEM_LSU_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  dmem_lsu #(.DEPTH_WORDS(DW), .READ_LAT(LAT)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_funct3(req_funct3),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = addr; v.wdata = wdata;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  // Driver: issue one request, wait (bounded) for its response, check timing and idle outputs.
  task automatic run_req(input string tag, input logic we, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
    int n;
    int lat;
    n = 0; lat = 0; rd = 32'h0; er = 1'b0;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL %s_ready_timeout got=0 exp=1", tag);
      return;
    end
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rsp_valid) begin
        lat = c;
        rd  = rsp_rdata;
        er  = rsp_err;
        break;
      end
      check($sformatf("%s_idle_rdata", tag), rsp_rdata, 32'h0);
      if (c == 1) check($sformatf("%s_busy_ready", tag), {31'h0, req_ready}, 32'h0);
    end
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL %s_rsp_timeout got=none exp=rsp_valid", tag);
      return;
    end
    check($sformatf("%s_latency", tag), lat, we ? 32'd1 : LAT);
    @(negedge clk);
    check($sformatf("%s_pulse", tag), {31'h0, rsp_valid}, 32'h0);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    bit          saw;

    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b010;
    req_addr = 32'h0; req_wdata = 32'h0;

    // Word 0x10 / 0x20 / 0x08 / 0x04 sequences; expected values hand-computed.
    add(1, 3'b010, 32'h10,  32'hDEADBEEF, 32'h0,        0);
    add(0, 3'b010, 32'h10,  32'h0,        32'hDEADBEEF, 0);
    add(1, 3'b010, 32'h10,  32'h00000000, 32'h0,        0);
    add(1, 3'b000, 32'h13,  32'h00000080, 32'h0,        0);
    add(0, 3'b000, 32'h13,  32'h0,        32'hFFFFFF80, 0);
    add(0, 3'b100, 32'h13,  32'h0,        32'h00000080, 0);
    add(0, 3'b010, 32'h10,  32'h0,        32'h80000000, 0);
    add(0, 3'b001, 32'h12,  32'h0,        32'hFFFF8000, 0);
    add(0, 3'b100, 32'h12,  32'h0,        32'h00000000, 0);
    add(1, 3'b010, 32'h20,  32'h12345678, 32'h0,        0);
    add(1, 3'b001, 32'h22,  32'h0000BEEF, 32'h0,        0);
    add(0, 3'b001, 32'h22,  32'h0,        32'hFFFFBEEF, 0);
    add(0, 3'b101, 32'h22,  32'h0,        32'h0000BEEF, 0);
    add(0, 3'b010, 32'h20,  32'h0,        32'hBEEF5678, 0);
    add(1, 3'b010, 4*DW+8,  32'h11111111, 32'h0,        0);
    add(0, 3'b010, 32'h08,  32'h0,        32'h11111111, 0);
    add(0, 3'b011, 32'h08,  32'h0,        32'h0,        1);
    add(1, 3'b100, 32'h08,  32'hFFFFFFFF, 32'h0,        1);
    add(1, 3'b111, 32'h08,  32'hFFFFFFFF, 32'h0,        1);
    add(0, 3'b110, 32'h08,  32'h0,        32'h0,        1);
    add(0, 3'b010, 32'h08,  32'h0,        32'h11111111, 0);
    add(1, 3'b010, 32'h04,  32'hCAFEF00D, 32'h0,        0);
    add(0, 3'b010, 32'h06,  32'h0,        MIS ? 32'h0 : 32'hCAFEF00D, MIS);
    add(1, 3'b001, 32'h05,  32'h0000AAAA, 32'h0,        MIS);
    add(0, 3'b010, 32'h04,  32'h0,        MIS ? 32'hCAFEF00D : 32'hCAFEAAAA, 0);
    add(0, 3'b101, 32'h07,  32'h0,        MIS ? 32'h0 : 32'h0000CAFE, MIS);
    add(0, 3'b000, 32'h07,  32'h0,        32'hFFFFFFCA, 0);
    add(1, 3'b000, 32'h21,  32'h123456A5, 32'h0,        0);
    add(0, 3'b010, 32'h20,  32'h0,        32'hBEEFA578, 0);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, req_ready}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", {31'h0, rsp_err}, 32'h0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_req($sformatf("v%0d", i), vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("v%0d_err", i), {31'h0, er}, {31'h0, vecs[i].exp_err});
    end

    // Reset one cycle after a load accept drops the pending response.
    saw = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h10;
    @(posedge clk);
    #1 req_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    check("midrst_ready_low", {31'h0, req_ready}, 32'h0);
    if (rsp_valid) saw = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (c == 0) check("midrst_ready_high", {31'h0, req_ready}, 32'h1);
      if (rsp_valid) saw = 1'b1;
    end
    check("midrst_no_rsp", {31'h0, saw}, 32'h0);

    // Memory survives reset.
    run_req("post_rst", 1'b0, 3'b010, 32'h10, 32'h0, rd, er);
    check("post_rst_rdata", rd, 32'h80000000);
    check("post_rst_err", {31'h0, er}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
